// File: rtl/mem_access.sv
// mem_access -- memory-stage data-access unit.
//
// Takes the effective address and store data of the instruction in MEM and
// runs one SRAM-like bus transaction for it. It aligns and extends load data,
// builds store byte strobes, flags misaligned accesses, and stalls the
// pipeline until the access completes.
//
// Ports
//   clk, rst           clock, synchronous active-low reset
//   m_valid            a real instruction occupies MEM
//   m_mem_read/write   load / store instruction
//   m_size             00 byte, 01 half, 10 word
//   m_load_sign        sign-extend load result
//   m_addr, m_wdata    effective address, store source
//   m_flush            exception/eret flush of MEM
//   m_advance          MEM may advance this cycle
//   data_*             bus request side (req/wr/size/addr/wdata/wstrb out,
//                      addr_ok/data_ok/rdata in)
//   m_rdata            aligned, extended load result (registered)
//   m_stall            MEM must hold
//   m_addr_err_load    AdEL
//   m_addr_err_store   AdES
//   m_badvaddr         faulting address
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transaction; bus outputs follow the live MEM inputs
// REQ       | request raised but not accepted; bus outputs held registered
// WAIT_DATA | request accepted, waiting for data_ok
// DRAIN     | access flushed after acceptance; swallow the data_ok
// DONE      | m_rdata valid, waiting for MEM to advance

module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic        m_mem_read,
  input  logic        m_mem_write,
  input  logic [1:0]  m_size,
  input  logic        m_load_sign,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_flush,
  input  logic        m_advance,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] m_rdata,
  output logic        m_stall,
  output logic        m_addr_err_load,
  output logic        m_addr_err_store,
  output logic [31:0] m_badvaddr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state;

  logic        is_mem;
  logic        misalign;
  logic        access;
  logic [31:0] live_wdata;
  logic [3:0]  live_wstrb;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_wr;
  logic        r_sign;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign is_mem = m_valid & (m_mem_read | m_mem_write);

  always_comb begin
    misalign = 1'b0;
    case (m_size)
      2'b01:   misalign = m_addr[0];
      2'b10:   misalign = |m_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign m_addr_err_load  = m_valid & m_mem_read & misalign;
  assign m_addr_err_store = m_valid & m_mem_write & misalign;
  assign m_badvaddr       = m_addr;

  assign access = is_mem & ~misalign & ~m_flush;

  // Store data is replicated across all lanes so the slave can pick any lane;
  // the strobes say which lanes actually land.
  always_comb begin
    live_wdata = m_wdata;
    live_wstrb = 4'b1111;
    case (m_size)
      2'b00: begin
        live_wdata = {4{m_wdata[7:0]}};
        live_wstrb = 4'b0001 << m_addr[1:0];
      end
      2'b01: begin
        live_wdata = {2{m_wdata[15:0]}};
        live_wstrb = m_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        live_wdata = m_wdata;
        live_wstrb = 4'b1111;
      end
    endcase
    if (!m_mem_write) live_wstrb = 4'b0000;
  end

  // In IDLE the bus follows the live inputs so an access can be accepted in
  // its first cycle. Outside IDLE the captured copy is shown, so the slave
  // sees a stable request even if MEM inputs wander. A low rst suppresses
  // the request at once, since the bus is reset together with this block.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = m_size;
    data_addr  = m_addr;
    data_wdata = live_wdata;
    data_wstrb = 4'b0000;
    if (state == S_IDLE) begin
      data_req   = rst & access;
      data_wr    = data_req & m_mem_write;
      data_wstrb = data_req ? live_wstrb : 4'b0000;
    end else begin
      data_size  = r_size;
      data_addr  = r_addr;
      data_wdata = r_wdata;
      if (state == S_REQ) begin
        data_req   = rst;
        data_wr    = rst & r_wr;
        data_wstrb = rst ? r_wstrb : 4'b0000;
      end
    end
  end

  assign m_stall = ((state == S_IDLE) & access) |
                   (state == S_REQ) |
                   (state == S_WAIT_DATA) |
                   (state == S_DRAIN);

  // Alignment uses the address captured at issue, not the live m_addr.
  always_comb begin
    ld_byte = data_rdata[7:0];
    case (r_addr[1:0])
      2'b00: ld_byte = data_rdata[7:0];
      2'b01: ld_byte = data_rdata[15:8];
      2'b10: ld_byte = data_rdata[23:16];
      2'b11: ld_byte = data_rdata[31:24];
      default: ld_byte = data_rdata[7:0];
    endcase
    ld_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (r_size)
      2'b00:   load_val = {{24{r_sign & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{r_sign & ld_half[15]}}, ld_half};
      default: load_val = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      m_rdata <= 32'h0;
      r_addr  <= 32'h0;
      r_size  <= 2'b00;
      r_wr    <= 1'b0;
      r_sign  <= 1'b0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            r_addr  <= m_addr;
            r_size  <= m_size;
            r_wr    <= m_mem_write;
            r_sign  <= m_load_sign;
            r_wdata <= live_wdata;
            r_wstrb <= live_wstrb;
            state   <= data_addr_ok ? S_WAIT_DATA : S_REQ;
          end
        end
        S_REQ: begin
          // Once accepted the data phase is owed even if flushed now.
          if (data_addr_ok) state <= m_flush ? S_DRAIN : S_WAIT_DATA;
          else if (m_flush) state <= S_IDLE;
        end
        S_WAIT_DATA: begin
          if (data_data_ok) begin
            if (m_flush) begin
              state <= S_IDLE;
            end else begin
              m_rdata <= load_val;
              state   <= S_DONE;
            end
          end else if (m_flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (data_data_ok) state <= S_IDLE;
        end
        S_DONE: begin
          if (m_advance | m_flush) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// accesses against a byte-lane reference model.

module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_mem_read, m_mem_write, m_load_sign, m_flush, m_advance;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic [31:0] m_rdata, m_badvaddr;
  logic        m_stall, m_addr_err_load, m_addr_err_store;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_mrdata = 32'h0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
    .m_size(m_size), .m_load_sign(m_load_sign), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_flush(m_flush), .m_advance(m_advance),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_rdata(m_rdata), .m_stall(m_stall),
    .m_addr_err_load(m_addr_err_load), .m_addr_err_store(m_addr_err_store),
    .m_badvaddr(m_badvaddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model: byte lanes, plain arithmetic ----
  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    return (int'(addr % 4) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic wr, input logic [1:0] size,
                                            input logic [31:0] addr);
    logic [3:0] s;
    int base;
    s = 4'b0000;
    base = int'(addr % 4);
    if (wr)
      for (int i = 0; i < 4; i++)
        if (i >= base && i < base + nbytes(size)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] o;
    int n;
    n = nbytes(size);
    o = 32'h0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr, input logic [31:0] rd);
    longint v, w;
    int n, base;
    n = nbytes(size);
    base = int'(addr % 4);
    v = 0;
    w = 1;
    for (int k = 0; k < n; k++) begin
      v = v + longint'(rd[8*(base+k) +: 8]) * w;
      w = w * 256;
    end
    if (sign && n < 4 && v >= w / 2) v = v - w;
    return 32'(v);
  endfunction

  // ---- drive helpers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    m_valid = 1'b0; m_mem_read = 1'b0; m_mem_write = 1'b0;
    m_flush = 1'b0; m_advance = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  // Runs one MEM access to completion with addr_ok after a_dly extra cycles
  // and data_ok d_dly cycles after acceptance. Entered and left with FSM idle.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                           input logic sign, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int a_dly, input int d_dly,
                           output logic [31:0] got, output int stalls);
    logic [31:0] e_wd, e_ld;
    logic [3:0]  e_strb;
    m_valid = 1'b1; m_mem_read = rd; m_mem_write = wr; m_size = size;
    m_load_sign = sign; m_addr = addr; m_wdata = wd;
    m_flush = 1'b0; m_advance = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    stalls = 0;
    #1;
    if (model_err(size, addr)) begin
      chk("adel", m_addr_err_load, rd);
      chk("ades", m_addr_err_store, wr);
      chk("badvaddr", m_badvaddr, addr);
      chk("err_req", data_req, 0);
      chk("err_stall", m_stall, 0);
      tick();
      chk("err_req_next", data_req, 0);
      set_idle();
      got = m_rdata;
      return;
    end
    chk("ok_no_adel", m_addr_err_load, 0);
    chk("ok_no_ades", m_addr_err_store, 0);
    e_wd   = model_wdata(size, wd);
    e_strb = model_strb(wr, size, addr);
    e_ld   = model_load(size, sign, addr, rdata);
    for (int c = 0; c <= a_dly; c++) begin
      data_addr_ok = (c == a_dly);
      #1;
      chk("req", data_req, 1);
      chk("req_wr", data_wr, wr);
      chk("req_addr", data_addr, addr);
      chk("req_size", data_size, size);
      chk("req_wdata", data_wdata, e_wd);
      chk("req_wstrb", data_wstrb, e_strb);
      chk("req_stall", m_stall, 1);
      stalls += int'(m_stall);
      tick();
      data_addr_ok = 1'b0;
      m_addr  = $urandom;
      m_wdata = $urandom;
    end
    for (int c = 0; c <= d_dly; c++) begin
      data_data_ok = (c == d_dly);
      data_rdata   = (c == d_dly) ? rdata : $urandom;
      #1;
      chk("wait_req", data_req, 0);
      chk("wait_stall", m_stall, 1);
      stalls += int'(m_stall);
      tick();
    end
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    exp_mrdata   = e_ld;
    chk("done_stall", m_stall, 0);
    chk("done_req", data_req, 0);
    if (rd) chk("load_data", m_rdata, e_ld);
    tick();
    chk("done_hold_stall", m_stall, 0);
    if (rd) chk("load_hold", m_rdata, e_ld);
    got = m_rdata;
    m_advance = 1'b1;
    tick();
    set_idle();
    #1;
    chk("after_adv_stall", m_stall, 0);
    chk("after_adv_req", data_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int st;
    logic rd, wr;
    logic [1:0] sz;
    logic [31:0] a;

    set_idle();
    rst = 1'b0; m_size = 2'b00; m_load_sign = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; data_rdata = 32'h0;
    tick(); tick();
    chk("rst_req", data_req, 0);
    chk("rst_wr", data_wr, 0);
    chk("rst_wstrb", data_wstrb, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_stall", m_stall, 0);
    rst = 1'b1;
    tick();

    // lw, minimum latency
    do_access(1, 0, 2'b10, 0, 32'h0000_1004, 32'h0, 32'hDEADBEEF, 0, 0, got, st);
    chk("lw_data", got, 32'hDEADBEEF);
    chk("lw_stall_cycles", st, 2);

    // lb / lbu from lane 3
    do_access(1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 32'h80112233, 0, 0, got, st);
    chk("lb_data", got, 32'hFFFFFF80);
    do_access(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h80112233, 1, 2, got, st);
    chk("lbu_data", got, 32'h00000080);

    // sh to upper half
    m_valid = 1; m_mem_read = 0; m_mem_write = 1; m_size = 2'b01;
    m_addr = 32'h0000_1002; m_wdata = 32'h0000ABCD;
    #1;
    chk("sh_wdata", data_wdata, 32'hABCDABCD);
    chk("sh_wstrb", data_wstrb, 4'b1100);
    chk("sh_wr", data_wr, 1);
    do_access(0, 1, 2'b01, 0, 32'h0000_1002, 32'h0000ABCD, 32'h0, 0, 1, got, st);

    // misaligned lw
    do_access(1, 0, 2'b10, 0, 32'h0000_1002, 32'h0, 32'h0, 0, 0, got, st);

    // addr_ok withheld 3 cycles on a store
    do_access(0, 1, 2'b10, 0, 32'h0000_2008, 32'h1234_5678, 32'h0, 3, 0, got, st);
    chk("held_stall_cycles", st, 5);

    // non-memory instruction and flushed access never stall or request
    m_valid = 1; m_mem_read = 0; m_mem_write = 0; #1;
    chk("nonmem_stall", m_stall, 0);
    chk("nonmem_req", data_req, 0);
    m_mem_read = 1; m_size = 2'b10; m_addr = 32'h100; m_flush = 1; #1;
    chk("flushed_req", data_req, 0);
    chk("flushed_stall", m_stall, 0);
    tick();
    set_idle();

    // flush in WAIT_DATA, data_ok two cycles later
    m_valid = 1; m_mem_read = 1; m_size = 2'b10; m_addr = 32'h0000_2000;
    data_addr_ok = 1; #1;
    tick();
    data_addr_ok = 0; m_flush = 1; #1;
    chk("fl_wait_stall", m_stall, 1);
    tick();
    m_flush = 0; m_addr = 32'h0000_3000; #1;
    chk("drain_req", data_req, 0);
    chk("drain_stall", m_stall, 1);
    tick();
    data_data_ok = 1; data_rdata = 32'h5555_AAAA; #1;
    chk("drain_ok_req", data_req, 0);
    tick();
    data_data_ok = 0; m_valid = 0; m_mem_read = 0; #1;
    chk("fl_idle_stall", m_stall, 0);
    chk("fl_idle_req", data_req, 0);
    chk("fl_rdata_kept", m_rdata, exp_mrdata);

    // reset while in REQ
    m_valid = 1; m_mem_read = 1; m_size = 2'b10; m_addr = 32'h0000_4000; #1;
    chk("pre_rst_req", data_req, 1);
    tick();
    chk("in_req", data_req, 1);
    rst = 0;
    tick();
    chk("rst_in_req", data_req, 0);
    rst = 1; set_idle(); #1;
    chk("post_rst_req", data_req, 0);
    chk("post_rst_stall", m_stall, 0);
    chk("post_rst_rdata", m_rdata, 0);
    exp_mrdata = 32'h0;
    tick();

    // randomized accesses
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        m_valid = 1; m_mem_read = 0; m_mem_write = 0; m_addr = $urandom; #1;
        chk("rnd_nonmem_stall", m_stall, 0);
        chk("rnd_nonmem_req", data_req, 0);
        tick();
        set_idle();
      end
      rd = $urandom_range(0, 1);
      wr = ~rd;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_access(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), got, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage data-access unit directly downstream of the execute stage.
- Takes the effective address (ex_out) and store data (rtdata) of the instruction now in MEM and drives the SRAM-like data bus.
- Aligns and extends load data, builds store byte strobes, detects load/store address errors, and stalls the pipeline until the access completes.

Parameters:
- None. Data path fixed at 32 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- m_valid  in  1  a real instruction occupies MEM.
- m_mem_read  in  1  load instruction.
- m_mem_write  in  1  store instruction.
- m_size  in  2  access size: 00 byte, 01 half, 10 word.
- m_load_sign  in  1  sign-extend load result (lb/lh).
- m_addr  in  32  effective address (ex_out).
- m_wdata  in  32  store source (rtdata).
- m_flush  in  1  exception/eret flush of MEM.
- m_advance  in  1  hazard unit lets MEM advance this cycle.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  equals m_size.
- data_addr  out  32  byte address.
- data_wdata  out  32  replicated store data.
- data_wstrb  out  4  byte enables.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data valid / write done.
- data_rdata  in  32  raw bus word.
- m_rdata  out  32  aligned, extended load result.
- m_stall  out  1  MEM must hold.
- m_addr_err_load  out  1  AdEL.
- m_addr_err_store  out  1  AdES.
- m_badvaddr  out  32  faulting address (= m_addr).

Behaviour:
- Access = m_valid & (m_mem_read | m_mem_write) & ~addr_err & ~m_flush.
- Address errors (combinational):
  - Error when half and addr[0]=1, or word and addr[1:0]≠00.
  - Reported on m_addr_err_load if a load, m_addr_err_store if a store.
  - No bus request is issued for a faulting access.
- FSM states:
  - IDLE: on access, drive data_req=1. If data_addr_ok=1 in the same cycle, go to WAIT_DATA; otherwise go to REQ.
  - REQ: hold data_req and all bus outputs stable until addr_ok, then go to WAIT_DATA. A flush here drops the request and returns to IDLE.
  - WAIT_DATA: on data_ok, latch aligned data into m_rdata and go to DONE. A flush goes to DRAIN instead.
  - DRAIN: wait for data_ok, discard the data, go to IDLE. m_stall=1 throughout.
  - DONE: m_rdata held. Go to IDLE on m_advance or m_flush.
- Bus outputs are registered at the IDLE→REQ transition. In IDLE they are driven combinationally from the inputs.
- At most one transaction is outstanding. A new request is never issued before the prior data_ok.
- m_stall is 1 when:
  - IDLE with an access present,
  - REQ, WAIT_DATA, or DRAIN.
- m_stall is 0 in DONE and for non-memory instructions.
- Minimum latency: addr_ok in cycle T and data_ok in T+1 puts the FSM in DONE at T+2. m_stall is high in T and T+1.
- Store data and strobes:
  - Byte: wdata = {4{byte}}, wstrb = 0001 shifted left by addr[1:0].
  - Half: wdata = {2{half}}, wstrb = 0011 if addr[1]=0, else 1100.
  - Word: wdata passed through, wstrb = 1111.
  - Loads: wstrb = 0000.
- Load alignment:
  - Byte: select rdata[8*addr[1:0]+:8].
  - Half: select rdata[16*addr[1]+:16].
  - Extend: sign if m_load_sign, zero otherwise.
  - The address used for alignment is the one registered at issue, not the live m_addr.
- Reset (rst=0 at a clock edge):
  - state=IDLE, data_req=0, data_wr=0, data_wstrb=0, m_rdata=0.
  - An outstanding bus transaction is abandoned. The bus is reset together with this block.

Test Plan:
- lw to 0x0000_1004, addr_ok same cycle, data_ok next cycle with rdata=0xDEADBEEF -> m_rdata=0xDEADBEEF, m_stall high for exactly 2 cycles.
- lb, m_load_sign=1, addr 0x...03, rdata=0x80112233 -> m_rdata=0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh of m_wdata=0x0000ABCD to addr 0x...02 -> data_wdata=0xABCDABCD, data_wstrb=1100, data_wr=1.
- lw at addr 0x...02 -> m_addr_err_load=1, m_badvaddr=addr, data_req stays 0, m_stall=0.
- addr_ok withheld 3 cycles -> data_req, data_addr, data_wdata, and data_wstrb remain stable until acceptance, and m_stall remains high.
- m_flush in WAIT_DATA, then data_ok 2 cycles later -> m_rdata unchanged, FSM returns to IDLE, no second request. Reset asserted in REQ -> data_req=0 on the next edge.
